// File: rtl/zx_vram_pkg.sv
// Shared constants and the queued Z80 write entry type for the ZX frame RAM arbiter.
package zx_vram_pkg;

  localparam int          VRAM_AW     = 13;
  localparam logic [15:0] BASE        = 16'h4000;
  localparam logic [15:0] LAST        = 16'h5AFF;
  localparam logic [12:0] ATTR_OFFSET = 13'h1800;
  localparam int          FRAME_BYTES = 6912;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } wr_entry_t;

endpackage

// File: rtl/zx_wr_fifo.sv
// Small synchronous FIFO for captured Z80 writes; a push into a full FIFO with no
// simultaneous pop is discarded and flagged on the drop strobe.
module zx_wr_fifo
  import zx_vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  wr_entry_t                push_entry,
  input  logic                     pop,
  output wr_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]     level_reg;
  logic            do_push, do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/zx_vram_arbiter.sv
// Single-port ZX frame RAM arbiter: video reads always win, Z80 writes are
// synchronised, edge-detected, queued and retired in idle slots.
module zx_vram_arbiter #(
  parameter int          DEPTH = 4,
  parameter int          AW    = zx_vram_pkg::VRAM_AW,
  parameter logic [15:0] BASE  = zx_vram_pkg::BASE,
  parameter logic [15:0] LAST  = zx_vram_pkg::LAST
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [15:0]            Z80_A,
  input  logic [7:0]             Z80_D,
  input  logic                   Z80_WR_N,
  input  logic                   Z80_MREQ_N,
  input  logic                   vid_req,
  input  logic [AW-1:0]          vid_addr,
  output logic [7:0]             vid_rdata,
  output logic                   vid_rvalid,
  output logic [AW-1:0]          ram_addr,
  output logic                   ram_we,
  output logic [7:0]             ram_wdata,
  input  logic [7:0]             ram_rdata,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   wr_overflow,
  output logic [7:0]             drop_count
);

  import zx_vram_pkg::*;

  logic [15:0] a_s1_reg, a_s2_reg;
  logic [7:0]  d_s1_reg, d_s2_reg;
  logic        wr_s1_reg, wr_s2_reg, wr_s3_reg;
  logic        mreq_s1_reg, mreq_s2_reg;

  logic        wr_event, in_window, pop, fifo_empty, fifo_full, fifo_drop;
  wr_entry_t   push_entry, head;

  logic [AW-1:0] ram_addr_reg;
  logic [7:0]    ram_wdata_reg;
  logic          ram_we_reg, req_d1_reg, rvalid_reg, overflow_reg;
  logic [7:0]    drop_count_reg;

  // Strobes reset high so the edge detector sees an idle bus after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_s1_reg    <= '0;
      a_s2_reg    <= '0;
      d_s1_reg    <= '0;
      d_s2_reg    <= '0;
      wr_s1_reg   <= 1'b1;
      wr_s2_reg   <= 1'b1;
      wr_s3_reg   <= 1'b1;
      mreq_s1_reg <= 1'b1;
      mreq_s2_reg <= 1'b1;
    end else begin
      a_s1_reg    <= Z80_A;
      a_s2_reg    <= a_s1_reg;
      d_s1_reg    <= Z80_D;
      d_s2_reg    <= d_s1_reg;
      wr_s1_reg   <= Z80_WR_N;
      wr_s2_reg   <= wr_s1_reg;
      wr_s3_reg   <= wr_s2_reg;
      mreq_s1_reg <= Z80_MREQ_N;
      mreq_s2_reg <= mreq_s1_reg;
    end
  end

  assign in_window       = (a_s2_reg >= BASE) && (a_s2_reg <= LAST);
  assign wr_event        = !mreq_s2_reg && wr_s3_reg && !wr_s2_reg && in_window;
  assign push_entry.addr = VRAM_AW'(a_s2_reg - BASE);
  assign push_entry.data = d_s2_reg;
  assign pop             = !vid_req && !fifo_empty;

  zx_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .srst       (RESET),
    .push       (wr_event),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .drop       (fifo_drop)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      ram_we_reg     <= 1'b0;
      req_d1_reg     <= 1'b0;
      rvalid_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (vid_req) begin
        ram_addr_reg <= vid_addr;
        ram_we_reg   <= 1'b0;
      end else if (!fifo_empty) begin
        ram_addr_reg  <= head.addr;
        ram_wdata_reg <= head.data;
        ram_we_reg    <= 1'b1;
      end else begin
        ram_we_reg <= 1'b0;
      end
      // RAM data lands one cycle after the registered address.
      req_d1_reg <= vid_req;
      rvalid_reg <= req_d1_reg;
      if (fifo_drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 1'b1;
      end
    end
  end

  assign ram_addr    = ram_addr_reg;
  assign ram_we      = ram_we_reg;
  assign ram_wdata   = ram_wdata_reg;
  assign vid_rdata   = ram_rdata;
  assign vid_rvalid  = rvalid_reg;
  assign wr_overflow = overflow_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Directed bench for zx_vram_arbiter with a behavioural frame RAM and per-cycle read checks.
module tb_zx_vram_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] Z80_A;
  logic [7:0]  Z80_D;
  logic        Z80_WR_N, Z80_MREQ_N;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_rvalid;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [2:0]  fifo_level;
  logic        wr_overflow;
  logic [7:0]  drop_count;

  zx_vram_arbiter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Z80_A      (Z80_A),
    .Z80_D      (Z80_D),
    .Z80_WR_N   (Z80_WR_N),
    .Z80_MREQ_N (Z80_MREQ_N),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .fifo_level (fifo_level),
    .wr_overflow(wr_overflow),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_rec_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          fall_cyc;
  int          rd_idx = 0;
  int          mark;
  bit          vid_on = 1'b0;
  wr_rec_t     wlog[$];
  logic [7:0]  mem [0:8191];
  bit          written [0:8191];
  logic [1:0]  req_hist = '0;
  logic [12:0] addr_hist0 = '0, addr_hist1 = '0;

  // Unwritten locations read back as a fixed pattern of their address.
  function automatic logic [7:0] init_val(input logic [12:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    if (RESET) begin
      req_hist <= '0;
    end else begin
      req_hist   <= {req_hist[0], vid_req};
      addr_hist0 <= vid_addr;
      addr_hist1 <= addr_hist0;
    end
  end

  always @(negedge CLK) begin
    if (ram_we) wlog.push_back('{ram_addr, ram_wdata, cyc});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: per-cycle read-path checks at the falling edge, then drive video just after the rising edge.
  task automatic step();
    @(negedge CLK);
    if (req_hist[0]) check_eq("no_we_during_read", {31'd0, ram_we}, 32'd0);
    if (req_hist[1] || vid_rvalid) check_eq("rvalid", {31'd0, vid_rvalid}, {31'd0, req_hist[1]});
    if (req_hist[1] && vid_rvalid) check_eq("rdata", {24'd0, vid_rdata}, {24'd0, init_val(addr_hist1)});
    @(posedge CLK);
    #1;
    if (vid_on) begin
      vid_req  = 1'b1;
      vid_addr = 13'h1800 + 13'(rd_idx % 8);
      rd_idx++;
    end else begin
      vid_req = 1'b0;
    end
  endtask

  task automatic z80_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    Z80_A = a;
    Z80_D = d;
    Z80_MREQ_N = 1'b0;
    step();
    Z80_WR_N = 1'b0;
    fall_cyc = cyc;
    repeat (hold) step();
    Z80_WR_N = 1'b1;
    Z80_MREQ_N = 1'b1;
    repeat (2) step();
    $display("z80 write A=%04h D=%02h hold=%0d level=%0d", a, d, hold, fifo_level);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [12:0] a, input logic [7:0] d);
    if (idx < wlog.size()) begin
      check_eq({tag, "_addr"}, {19'd0, wlog[idx].addr}, {19'd0, a});
      check_eq({tag, "_data"}, {24'd0, wlog[idx].data}, {24'd0, d});
    end else begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    RESET = 1'b1;
    Z80_A = '0;
    Z80_D = '0;
    Z80_WR_N = 1'b1;
    Z80_MREQ_N = 1'b1;
    vid_req = 1'b0;
    vid_addr = '0;
    repeat (3) step();
    @(negedge CLK);
    check_eq("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    check_eq("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    check_eq("rst_rvalid", {31'd0, vid_rvalid}, 32'd0);
    check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
    check_eq("rst_overflow", {31'd0, wr_overflow}, 32'd0);
    check_eq("rst_drops", {24'd0, drop_count}, 32'd0);
    step();
    RESET = 1'b0;
    step();

    // 1: single write retires once with the expected latency
    mark = wlog.size();
    z80_write(16'h4000, 8'hA5, 3);
    repeat (3) step();
    check_eq("t1_count", wlog.size() - mark, 32'd1);
    check_log("t1", mark, 13'h0000, 8'hA5);
    if (mark < wlog.size())
      check_eq("t1_latency_4to5", {31'd0, (wlog[mark].cyc - fall_cyc) inside {[4:5]}}, 32'd1);
    check_eq("t1_level", {29'd0, fifo_level}, 32'd0);

    // 2: video reads block writes; writes retire afterwards in order, back to back
    vid_on = 1'b1;
    step();
    mark = wlog.size();
    for (int i = 0; i < 3; i++) z80_write(16'h4010 + 16'(i), 8'hB0 + 8'(i), 3);
    repeat (4) step();
    check_eq("t2_level_held", {29'd0, fifo_level}, 32'd3);
    check_eq("t2_no_writes", wlog.size() - mark, 32'd0);
    vid_on = 1'b0;
    repeat (6) step();
    check_eq("t2_count", wlog.size() - mark, 32'd3);
    for (int i = 0; i < 3; i++) check_log("t2", mark + i, 13'h0010 + 13'(i), 8'hB0 + 8'(i));
    if (wlog.size() - mark == 3) begin
      check_eq("t2_consec_1", wlog[mark+1].cyc - wlog[mark].cyc, 32'd1);
      check_eq("t2_consec_2", wlog[mark+2].cyc - wlog[mark+1].cyc, 32'd1);
    end

    // 3: address window boundaries
    mark = wlog.size();
    z80_write(16'h3FFF, 8'h77, 3);
    z80_write(16'h5B00, 8'h88, 3);
    repeat (4) step();
    check_eq("t3_level", {29'd0, fifo_level}, 32'd0);
    check_eq("t3_drops", {24'd0, drop_count}, 32'd0);
    check_eq("t3_no_writes", wlog.size() - mark, 32'd0);
    z80_write(16'h5AFF, 8'h3C, 3);
    repeat (4) step();
    check_eq("t3_last_count", wlog.size() - mark, 32'd1);
    check_log("t3_last", mark, 13'h1AFF, 8'h3C);

    // 4: a long WR_N low pushes once; a fresh fall pushes again
    mark = wlog.size();
    z80_write(16'h4100, 8'h11, 20);
    check_eq("t4_single", wlog.size() - mark, 32'd1);
    z80_write(16'h4101, 8'h22, 3);
    repeat (4) step();
    check_eq("t4_count", wlog.size() - mark, 32'd2);
    check_log("t4_a", mark, 13'h0100, 8'h11);
    check_log("t4_b", mark + 1, 13'h0101, 8'h22);

    // 5: overflow while video holds the port
    vid_on = 1'b1;
    step();
    mark = wlog.size();
    for (int i = 0; i < 6; i++) z80_write(16'h4200 + 16'(i), 8'h60 + 8'(i), 3);
    repeat (4) step();
    check_eq("t5_level_full", {29'd0, fifo_level}, 32'd4);
    check_eq("t5_overflow", {31'd0, wr_overflow}, 32'd1);
    check_eq("t5_drops", {24'd0, drop_count}, 32'd2);
    vid_on = 1'b0;
    repeat (8) step();
    check_eq("t5_count", wlog.size() - mark, 32'd4);
    for (int i = 0; i < 4; i++) check_log("t5", mark + i, 13'h0200 + 13'(i), 8'h60 + 8'(i));
    check_eq("t5_overflow_sticky", {31'd0, wr_overflow}, 32'd1);
    check_eq("t5_drops_sticky", {24'd0, drop_count}, 32'd2);

    // 6: reset with queued writes and a read in flight
    vid_on = 1'b1;
    step();
    for (int i = 0; i < 3; i++) z80_write(16'h4300 + 16'(i), 8'hC0 + 8'(i), 3);
    repeat (2) step();
    check_eq("t6_level_before", {29'd0, fifo_level}, 32'd3);
    RESET = 1'b1;
    step();
    @(negedge CLK);
    check_eq("t6_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("t6_rvalid", {31'd0, vid_rvalid}, 32'd0);
    check_eq("t6_level", {29'd0, fifo_level}, 32'd0);
    vid_on = 1'b0;
    step();
    RESET = 1'b0;
    mark = wlog.size();
    repeat (10) step();
    check_eq("t6_no_writes", wlog.size() - mark, 32'd0);
    check_eq("t6_overflow", {31'd0, wr_overflow}, 32'd0);
    check_eq("t6_drops", {24'd0, drop_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
